// File: rtl/nmos_famux_n.sv
// nmos_famux_n: N-input, WIDTH-bit dynamic-node latching mux with precharge,
// leakage decay, force-high override and select-fight detection.
`default_nettype none

module nmos_famux_n #(
  parameter int              N_IN      = 3,
  parameter int              WIDTH     = 1,
  parameter int              RES_MODE  = 0,
  parameter int              DECAY_CYC = 0,
  parameter logic [WIDTH-1:0] DECAY_VAL = '0,
  parameter logic [WIDTH-1:0] RST_VAL   = '0
) (
  input  logic                    main_clk,
  input  logic                    main_rst,
  input  logic [N_IN*WIDTH-1:0]   d,
  input  logic [N_IN-1:0]         sel,
  input  logic                    pc,
  input  logic                    ff,
  output logic [WIDTH-1:0]        q,
  output logic                    stale,
  output logic                    conflict
);

  // Keep the age counter at least one bit wide so DECAY_CYC=0 stays legal.
  localparam int AGE_W = (DECAY_CYC > 0) ? $clog2(DECAY_CYC + 1) : 1;
  localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'((DECAY_CYC > 0) ? DECAY_CYC - 1 : 0);
  localparam logic [AGE_W-1:0] AGE_SAT  = AGE_W'(DECAY_CYC);

  logic [WIDTH-1:0] node;
  logic [AGE_W-1:0] age;
  logic [WIDTH-1:0] resolved;
  logic [WIDTH-1:0] ref_val;
  logic             found;
  logic             differ;
  logic             conflict_next;

  always_comb begin
    resolved = (RES_MODE == 1) ? {WIDTH{1'b1}} : '0;
    ref_val  = '0;
    found    = 1'b0;
    differ   = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      if (sel[i]) begin
        if (RES_MODE == 1) resolved = resolved & d[i*WIDTH +: WIDTH];
        else               resolved = d[i*WIDTH +: WIDTH];
        // A fight is any selected input differing from the first selected one.
        if (!found) begin
          ref_val = d[i*WIDTH +: WIDTH];
          found   = 1'b1;
        end else if (d[i*WIDTH +: WIDTH] != ref_val) begin
          differ = 1'b1;
        end
      end
    end
    conflict_next = (N_IN > 1) && differ;
  end

  always_ff @(posedge main_clk or posedge main_rst) begin
    if (main_rst) begin
      node     <= RST_VAL;
      age      <= '0;
      stale    <= 1'b0;
      conflict <= 1'b0;
    end else begin
      conflict <= conflict_next;
      if (|sel) begin
        node  <= resolved;
        age   <= '0;
        stale <= 1'b0;
      end else if (pc) begin
        node  <= {WIDTH{1'b1}};
        age   <= '0;
        stale <= 1'b0;
      end else if (DECAY_CYC > 0) begin
        if (age < AGE_LAST) begin
          age <= age + 1'b1;
        end else if (age == AGE_LAST) begin
          node  <= DECAY_VAL;
          stale <= 1'b1;
          age   <= AGE_SAT;
        end
      end
    end
  end

  assign q = ff ? {WIDTH{1'b1}} : node;

endmodule

`default_nettype wire

// File: tb/tb_nmos_famux_n.sv
// tb_nmos_famux_n: directed checks of a priority/decaying instance (a) and a
// wired-AND/non-decaying instance (b) driven from the same stimulus.
`default_nettype none

module tb_nmos_famux_n;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] d   = '0;
  logic [2:0]  sel = '0;
  logic        pc  = 1'b0;
  logic        ff  = 1'b0;
  logic [7:0]  qa, qb;
  logic        stale_a, stale_b, conf_a, conf_b;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  nmos_famux_n #(.N_IN(3), .WIDTH(8), .RES_MODE(0), .DECAY_CYC(4),
                 .DECAY_VAL(8'h00), .RST_VAL(8'h5A)) dut_a (
    .main_clk(clk), .main_rst(rst), .d(d), .sel(sel), .pc(pc), .ff(ff),
    .q(qa), .stale(stale_a), .conflict(conf_a));

  nmos_famux_n #(.N_IN(3), .WIDTH(8), .RES_MODE(1), .DECAY_CYC(0),
                 .DECAY_VAL(8'h00), .RST_VAL(8'h5A)) dut_b (
    .main_clk(clk), .main_rst(rst), .d(d), .sel(sel), .pc(pc), .ff(ff),
    .q(qb), .stale(stale_b), .conflict(conf_b));

  typedef struct {
    logic [2:0] sel;
    logic [7:0] d0, d1, d2;
    logic       pc;
    logic [7:0] qa;
    logic       ca;
    logic [7:0] qb;
    logic       cb;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs, take one rising edge, settle just after it.
  task automatic step(input logic [2:0] s, input logic [7:0] a0, input logic [7:0] a1,
                      input logic [7:0] a2, input logic p);
    sel = s; d = {a2, a1, a0}; pc = p;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(3'b000, 8'h00, 8'h00, 8'h00, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{3'b011, 8'h11, 8'h22, 8'h33, 1'b0, 8'h22, 1'b1, 8'h00, 1'b1};
    vecs[1] = '{3'b100, 8'h11, 8'h22, 8'h33, 1'b0, 8'h33, 1'b0, 8'h33, 1'b0};
    vecs[2] = '{3'b101, 8'hF0, 8'h00, 8'h3C, 1'b0, 8'h3C, 1'b1, 8'h30, 1'b1};
    vecs[3] = '{3'b101, 8'h0F, 8'h00, 8'h0F, 1'b0, 8'h0F, 1'b0, 8'h0F, 1'b0};
    vecs[4] = '{3'b000, 8'h0F, 8'h00, 8'h0F, 1'b1, 8'hFF, 1'b0, 8'hFF, 1'b0};
    vecs[5] = '{3'b111, 8'hAA, 8'hAA, 8'hAA, 1'b1, 8'hAA, 1'b0, 8'hAA, 1'b0};
    vecs[6] = '{3'b110, 8'h00, 8'h55, 8'h55, 1'b0, 8'h55, 1'b0, 8'h55, 1'b0};
    vecs[7] = '{3'b001, 8'h12, 8'hFF, 8'h00, 1'b0, 8'h12, 1'b0, 8'h12, 1'b0};

    // Reset values, then a mid-cycle async pulse with no edge.
    #12;
    chk("rst_qa", qa, 8'h5A);
    chk("rst_stale", stale_a, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    step(3'b001, 8'h99, 8'h00, 8'h00, 1'b0);
    chk("pre_pulse_q", qa, 8'h99);
    #2 rst = 1'b1;
    #1;
    chk("pulse_qa", qa, 8'h5A);
    chk("pulse_qb", qb, 8'h5A);
    chk("pulse_conf", conf_a, 1'b0);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      step(vecs[i].sel, vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].pc);
      chk($sformatf("vec%0d_qa", i), qa, vecs[i].qa);
      chk($sformatf("vec%0d_ca", i), conf_a, vecs[i].ca);
      chk($sformatf("vec%0d_qb", i), qb, vecs[i].qb);
      chk($sformatf("vec%0d_cb", i), conf_b, vecs[i].cb);
      chk($sformatf("vec%0d_st", i), stale_a, 1'b0);
    end

    // Decay after 4 idle edges, hold, then precharge clears.
    step(3'b001, 8'hAA, 8'h00, 8'h00, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      idle();
      chk($sformatf("decay_hold%0d_q", k), qa, 8'hAA);
      chk($sformatf("decay_hold%0d_st", k), stale_a, 1'b0);
    end
    idle();
    chk("decay_q", qa, 8'h00);
    chk("decay_st", stale_a, 1'b1);
    chk("nodecay_qb", qb, 8'hAA);
    chk("nodecay_stb", stale_b, 1'b0);
    idle(); idle();
    chk("decay_sat_q", qa, 8'h00);
    chk("decay_sat_st", stale_a, 1'b1);
    step(3'b000, 8'h00, 8'h00, 8'h00, 1'b1);
    chk("pc_q", qa, 8'hFF);
    chk("pc_st", stale_a, 1'b0);

    // Refresh at edge 3 pushes decay out to edge 7.
    step(3'b001, 8'h77, 8'h00, 8'h00, 1'b0);
    idle(); idle();
    chk("refresh_e2_q", qa, 8'h77);
    step(3'b010, 8'h00, 8'h66, 8'h00, 1'b0);
    idle(); idle(); idle();
    chk("refresh_e6_q", qa, 8'h66);
    chk("refresh_e6_st", stale_a, 1'b0);
    idle();
    chk("refresh_e7_q", qa, 8'h00);
    chk("refresh_e7_st", stale_a, 1'b1);

    // Force-high override.
    step(3'b001, 8'h12, 8'h00, 8'h00, 1'b0);
    ff = 1'b1;
    #1;
    chk("ff_q", qa, 8'hFF);
    step(3'b001, 8'h34, 8'h00, 8'h00, 1'b0);
    chk("ff_write_q", qa, 8'hFF);
    ff = 1'b0;
    #1;
    chk("ff_drop_q", qa, 8'h34);
    step(3'b011, 8'h12, 8'h34, 8'h00, 1'b0);
    chk("fight_conf", conf_a, 1'b1);
    sel = 3'b000;
    ff = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("ff_rst_q", qa, 8'hFF);
    chk("ff_rst_conf", conf_a, 1'b0);
    ff = 1'b0;
    #1;
    chk("rst_after_ff_q", qa, 8'h5A);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
